// File: rtl/divider_16.sv
`default_nettype none
// ============================================================================
// Module   : divider_16
// Purpose  : Signed Q1.15 fractional divider. Restoring radix-2 iteration,
//            one quotient bit per clock, with early exit for divide-by-zero,
//            zero dividend and quotient-overflow (saturation) cases.
// Config   : define DIVIDER_16_ROUND_EN to run one guard iteration and
//            round the magnitude to nearest instead of truncating.
// Revision : 1.0 - initial release
// ============================================================================
module divider_16 (
   input  logic        I_CLK,
   input  logic        I_RST_N,
   input  logic        I_VLD,
   input  logic [15:0] I_DIVIDEND,
   input  logic [15:0] I_DIVISOR,
   output logic        O_BUSY,
   output logic        O_VLD,
   output logic [15:0] O_QUOTIENT,
   output logic        O_DIV0
);

`ifdef DIVIDER_16_ROUND_EN
   localparam logic [4:0] c_iter = 5'd16;
`else
   localparam logic [4:0] c_iter = 5'd15;
`endif
   localparam logic [15:0] c_pos_sat = 16'h7FFF;
   localparam logic [15:0] c_neg_sat = 16'h8001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state, w_state_nx;
   logic [15:0] r_rem,   w_rem_nx;    // partial remainder, always < divisor
   logic [15:0] r_div,   w_div_nx;    // divisor magnitude
   logic [15:0] r_quo,   w_quo_nx;    // quotient bits, shifted in MSB first
   logic        r_sign,  w_sign_nx;
   logic [4:0]  r_cnt,   w_cnt_nx;
   logic        r_vld,   w_vld_nx;
   logic [15:0] r_q_out, w_q_out_nx;
   logic        r_div0,  w_div0_nx;

   logic [15:0] w_dvd_mag;
   logic [15:0] w_dsr_mag;
   logic [16:0] w_rem_sh;
   logic [15:0] w_rem_sub;
   logic        w_ge;
   logic [15:0] w_mag;
   logic [15:0] w_result;

   // Two's-complement magnitude; 0x8000 maps onto itself, which is the
   // desired 16-bit magnitude of -1.0.
   assign w_dvd_mag = I_DIVIDEND[15] ? (~I_DIVIDEND + 16'd1) : I_DIVIDEND;
   assign w_dsr_mag = I_DIVISOR[15]  ? (~I_DIVISOR  + 16'd1) : I_DIVISOR;

   // One restoring step. The remainder is below the divisor (<= 0x8000), so
   // the shifted value needs 17 bits but the difference always fits 16.
   assign w_rem_sh  = {r_rem, 1'b0};
   assign w_rem_sub = w_rem_sh[15:0] - r_div;
   assign w_ge      = (w_rem_sh >= {1'b0, r_div});

`ifdef DIVIDER_16_ROUND_EN
   logic [15:0] w_round;
   // Guard bit rounds half up; a carry into bit 15 saturates to +max.
   assign w_round = {1'b0, r_quo[15:1]} + {15'd0, r_quo[0]};
   assign w_mag   = w_round[15] ? c_pos_sat : w_round;
`else
   // Quotient < 1.0 here, so bit 15 of the 15-iteration result is zero.
   assign w_mag   = r_quo;
`endif

   assign w_result = r_sign ? (~w_mag + 16'd1) : w_mag;

   // State register plus datapath registers; reset wipes everything at once.
   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         r_state <= IDLE;
         r_rem   <= '0;
         r_div   <= '0;
         r_quo   <= '0;
         r_sign  <= 1'b0;
         r_cnt   <= '0;
         r_vld   <= 1'b0;
         r_q_out <= '0;
         r_div0  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_rem   <= w_rem_nx;
         r_div   <= w_div_nx;
         r_quo   <= w_quo_nx;
         r_sign  <= w_sign_nx;
         r_cnt   <= w_cnt_nx;
         r_vld   <= w_vld_nx;
         r_q_out <= w_q_out_nx;
         r_div0  <= w_div0_nx;
      end
   end

   // Next-state and next-datapath logic; result outputs default to zero so
   // they are only non-zero during the DONE strobe.
   always_comb begin
      w_state_nx = r_state;
      w_rem_nx   = r_rem;
      w_div_nx   = r_div;
      w_quo_nx   = r_quo;
      w_sign_nx  = r_sign;
      w_cnt_nx   = r_cnt;
      w_vld_nx   = 1'b0;
      w_q_out_nx = '0;
      w_div0_nx  = 1'b0;
      case (r_state)
         IDLE: begin
            if (I_VLD) begin
               w_state_nx = CALC;
               w_rem_nx   = w_dvd_mag;
               w_div_nx   = w_dsr_mag;
               w_sign_nx  = I_DIVIDEND[15] ^ I_DIVISOR[15];
               w_quo_nx   = '0;
               w_cnt_nx   = '0;
            end
         end
         CALC: begin
            // Early-exit checks happen on the first CALC edge, before any
            // remainder bits are consumed.
            if ((r_cnt == 5'd0) && (r_div == 16'd0)) begin
               w_state_nx = DONE;
               w_vld_nx   = 1'b1;
               w_q_out_nx = c_pos_sat;
               w_div0_nx  = 1'b1;
            end else if ((r_cnt == 5'd0) && (r_rem == 16'd0)) begin
               w_state_nx = DONE;
               w_vld_nx   = 1'b1;
               w_q_out_nx = 16'h0000;
            end else if ((r_cnt == 5'd0) && (r_rem >= r_div)) begin
               w_state_nx = DONE;
               w_vld_nx   = 1'b1;
               w_q_out_nx = r_sign ? c_neg_sat : c_pos_sat;
            end else if (r_cnt == c_iter) begin
               w_state_nx = DONE;
               w_vld_nx   = 1'b1;
               w_q_out_nx = w_result;
            end else begin
               w_rem_nx = w_ge ? w_rem_sub : w_rem_sh[15:0];
               w_quo_nx = {r_quo[14:0], w_ge};
               w_cnt_nx = r_cnt + 5'd1;
            end
         end
         DONE: begin
            w_state_nx = IDLE;
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   assign O_BUSY     = (r_state != IDLE);
   assign O_VLD      = r_vld;
   assign O_QUOTIENT = r_q_out;
   assign O_DIV0     = r_div0;

endmodule
`default_nettype wire

// File: doc/divider_16.md
DIVIDER_16 -- requirements
Module: divider_16

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low. Ports: I_CLK  input  1  clock, all state on rising edge.
REQ-002 SHALL provide I_RST_N  input  1  asynchronous active-low reset.
REQ-003 SHALL provide I_VLD  input  1  operands valid; accepted only when O_BUSY=0.
REQ-004 SHALL provide I_DIVIDEND  input  16  two's-complement Q1.15 dividend.
REQ-005 SHALL provide I_DIVISOR  input  16  two's-complement Q1.15 divisor.
REQ-006 SHALL provide O_BUSY  output  1  high from the accept edge until the edge that drops O_VLD.
REQ-007 SHALL provide O_VLD  output  1  one-cycle result strobe.
REQ-008 SHALL provide O_QUOTIENT  output  16  two's-complement Q1.15 quotient, valid only while O_VLD=1.
REQ-009 SHALL provide O_DIV0  output  1  divisor-was-zero flag, valid only while O_VLD=1.

Function
REQ-010 SHALL implement FSM states IDLE, CALC and DONE.
REQ-011 SHALL define acceptance as I_VLD=1 in IDLE at edge k: latch sign = dividend[15]^divisor[15] and 16-bit magnitudes; |0x8000| = 0x8000.
REQ-012 SHALL ignore I_VLD while O_BUSY=1, with no queuing and no effect on the current operation.
REQ-013 SHALL, if divisor=0 at acceptance, go IDLE->DONE at edge k+1 with O_QUOTIENT=0x7FFF and O_DIV0=1, regardless of dividend sign.
REQ-014 SHALL, if dividend=0 (divisor≠0), go IDLE->DONE at edge k+1 with O_QUOTIENT=0x0000; a negative zero is never produced.
REQ-015 SHALL, if |dividend|>=|divisor| (both ≠0), go IDLE->DONE at edge k+1 with saturated O_QUOTIENT=0x7FFF for positive sign and 0x8001 for negative sign.
REQ-016 SHALL otherwise enter CALC, running restoring radix-2 division of (|dividend|<<15)/|divisor| at one quotient bit per edge, MSB first, for N edges (N=15; 16 with rounding, see REQ-024).
REQ-017 SHALL go CALC->DONE on the edge producing the last bit; O_QUOTIENT is the magnitude, truncated, negated in two's complement when sign=1.
REQ-018 SHALL register O_VLD=1 and the result in DONE; non-early-exit results appear at edge k+N+1.
REQ-019 SHALL go DONE->IDLE on the next edge, where O_VLD=0, O_BUSY=0, O_QUOTIENT=0 and O_DIV0=0; a new operand set is accepted at the earliest one edge later.
REQ-020 SHALL hold O_QUOTIENT=0 and O_DIV0=0 whenever O_VLD=0.

Reset
REQ-021 SHALL, on I_RST_N=0 at any time including mid-CALC, immediately force state IDLE, O_BUSY=0, O_VLD=0, O_QUOTIENT=0x0000, O_DIV0=0, and clear the remainder, quotient and sign registers.
REQ-022 SHALL not produce O_VLD for an operation interrupted by reset.
REQ-023 SHALL allow acceptance on the first rising edge after reset release.

Configuration
REQ-024 SHALL honour macro DIVIDER_16_ROUND_EN: when defined, CALC runs 16 iterations (one guard bit) and the magnitude is q[15:1]+q[0], saturated to 0x7FFF if it reaches 0x8000, so non-early-exit latency is edge k+17; when undefined, 15 iterations with truncation and latency edge k+16.
REQ-025 SHALL keep early-exit cases (REQ-013 to REQ-015) at edge k+1 with identical values in both configurations.

Verification
REQ-026 SHALL cover: 0x2000 / 0x4000 -> O_QUOTIENT=0x4000, O_VLD at k+16 (k+17 with ROUND_EN), O_DIV0=0.
REQ-027 SHALL cover: 0xE000 / 0x4000 -> 0xC000; 0x2000 / 0xC000 -> 0xC000.
REQ-028 SHALL cover: 0x1000 / 0x3000 -> 0x2AAA without ROUND_EN, 0x2AAB with it.
REQ-029 SHALL cover: 0x4000 / 0x2000 -> 0x7FFF at k+1; 0xC000 / 0x2000 -> 0x8001; 0x1234 / 0x0000 -> 0x7FFF with O_DIV0=1 at k+1; 0x0000 / 0x1234 -> 0x0000.
REQ-030 SHALL cover: a second I_VLD with different operands during CALC -> ignored, and the first result is unchanged.
REQ-031 SHALL cover: I_RST_N pulsed low at k+5 -> all outputs 0 immediately, no O_VLD, and a fresh 0x2000 / 0x4000 after release returns 0x4000.
